// File: rtl/vga_if.sv
// Pixel-stream bundle passed along the overlay chain: the timing generator
// drives it as master, and the rect/sprite drawers consume it as slave.
interface vga_if;
  logic [11:0] hcount;
  logic [11:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/vga_timing_gen.sv
// Video timing source: nested pixel/line counters with sync and blank decode
// registered alongside them, so every vga_out field describes the same pixel.
module vga_timing_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 23,
  parameter bit H_POL    = 1'b1,
  parameter bit V_POL    = 1'b1
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  vga_if.master  vga_out,
  output logic   frame_start
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOT > 4096 || V_TOT > 4096) begin : g_tot_check
    $fatal(1, "vga_timing_gen: H_TOT/V_TOT must not exceed 4096");
  end

  localparam logic [11:0] H_LAST     = 12'(H_TOT - 1);
  localparam logic [11:0] V_LAST     = 12'(V_TOT - 1);
  localparam logic [11:0] H_ACT_C    = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT_C    = 12'(V_ACTIVE);
  localparam logic [11:0] HS_START   = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END     = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_START   = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END     = 12'(V_ACTIVE + V_FP + V_SYNC);

  logic [11:0] hcount_q, hcount_d;
  logic [11:0] vcount_q, vcount_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        hblnk_q, hblnk_d;
  logic        vblnk_q, vblnk_d;
  logic        frame_start_q, frame_start_d;

  always_comb begin
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    frame_start_d = 1'b0;
    if (en) begin
      if (hcount_q == H_LAST) begin
        hcount_d = '0;
        if (vcount_q == V_LAST) begin
          vcount_d      = '0;
          frame_start_d = 1'b1;
        end else begin
          vcount_d = vcount_q + 12'd1;
        end
      end else begin
        hcount_d = hcount_q + 12'd1;
      end
    end
    // Decode from the next counter values so sync/blank land in the same flop stage.
    hblnk_d = (hcount_d >= H_ACT_C);
    vblnk_d = (vcount_d >= V_ACT_C);
    hsync_d = ((hcount_d >= HS_START) && (hcount_d < HS_END)) ? H_POL : ~H_POL;
    vsync_d = ((vcount_d >= VS_START) && (vcount_d < VS_END)) ? V_POL : ~V_POL;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      hsync_q       <= ~H_POL;
      vsync_q       <= ~V_POL;
      hblnk_q       <= 1'b0;
      vblnk_q       <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      hblnk_q       <= hblnk_d;
      vblnk_q       <= vblnk_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga_out.hcount = hcount_q;
  assign vga_out.vcount = vcount_q;
  assign vga_out.hsync  = hsync_q;
  assign vga_out.vsync  = vsync_q;
  assign vga_out.hblnk  = hblnk_q;
  assign vga_out.vblnk  = vblnk_q;
  assign vga_out.rgb    = 12'h000;
  assign frame_start    = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-mode instance and a small inverted-polarity
// instance run side by side against a pixel-position reference model.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic fs0, fs1;

  vga_if vif0 ();
  vga_if vif1 ();

  vga_timing_gen dut0 (
    .clk(clk), .rst(rst), .en(en), .vga_out(vif0), .frame_start(fs0)
  );

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(2),
    .H_POL(1'b0),  .V_POL(1'b0)
  ) dut1 (
    .clk(clk), .rst(rst), .en(en), .vga_out(vif1), .frame_start(fs1)
  );

  always #5 clk = ~clk;

  localparam int HA[2] = '{800, 16};
  localparam int HF[2] = '{40, 2};
  localparam int HS[2] = '{128, 3};
  localparam int HB[2] = '{88, 2};
  localparam int VA[2] = '{600, 8};
  localparam int VF[2] = '{1, 1};
  localparam int VS[2] = '{4, 2};
  localparam int VB[2] = '{23, 2};
  localparam int HP[2] = '{1, 0};
  localparam int VP[2] = '{1, 0};

  int checks = 0;
  int errors = 0;
  int mh[2];
  int mv[2];
  int mfs[2];
  longint cyc = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int htot(input int i);
    return HA[i] + HF[i] + HS[i] + HB[i];
  endfunction

  function automatic int vtot(input int i);
    return VA[i] + VF[i] + VS[i] + VB[i];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mh[i] = 0; mv[i] = 0; mfs[i] = 0;
    end
  endtask

  // One pixel-clock step of the reference: position advances raster-order.
  task automatic model_advance();
    for (int i = 0; i < 2; i++) begin
      int lin;
      lin = mv[i] * htot(i) + mh[i] + 1;
      if (lin == htot(i) * vtot(i)) lin = 0;
      mfs[i] = (lin == 0) ? 1 : 0;
      mh[i] = lin % htot(i);
      mv[i] = lin / htot(i);
    end
  endtask

  task automatic compare_dut(input int i, input logic [11:0] hc, input logic [11:0] vc,
                             input logic hs, input logic vs, input logic hb, input logic vb,
                             input logic [11:0] rgb, input logic fs);
    string p;
    int hs_exp, vs_exp;
    p = (i == 0) ? "d0" : "d1";
    hs_exp = (mh[i] >= HA[i] + HF[i] && mh[i] < HA[i] + HF[i] + HS[i]) ? HP[i] : 1 - HP[i];
    vs_exp = (mv[i] >= VA[i] + VF[i] && mv[i] < VA[i] + VF[i] + VS[i]) ? VP[i] : 1 - VP[i];
    check({p, "_hcount"}, int'(hc), mh[i]);
    check({p, "_vcount"}, int'(vc), mv[i]);
    check({p, "_hsync"}, int'(hs), hs_exp);
    check({p, "_vsync"}, int'(vs), vs_exp);
    check({p, "_hblnk"}, int'(hb), (mh[i] >= HA[i]) ? 1 : 0);
    check({p, "_vblnk"}, int'(vb), (mv[i] >= VA[i]) ? 1 : 0);
    check({p, "_rgb"}, int'(rgb), 0);
    check({p, "_frame_start"}, int'(fs), mfs[i]);
  endtask

  task automatic compare_all();
    compare_dut(0, vif0.hcount, vif0.vcount, vif0.hsync, vif0.vsync,
                vif0.hblnk, vif0.vblnk, vif0.rgb, fs0);
    compare_dut(1, vif1.hcount, vif1.vcount, vif1.hsync, vif1.vsync,
                vif1.hblnk, vif1.vblnk, vif1.rgb, fs1);
  endtask

  // Inputs change on the falling edge; async reset is checked 1 time unit later,
  // registered behaviour 1 time unit after the rising edge.
  task automatic cycle(input logic e, input logic r);
    @(negedge clk);
    en  = e;
    rst = r;
    if (r) begin
      model_reset();
      #1 compare_all();
    end
    @(posedge clk);
    cyc++;
    if (!r) begin
      if (e) model_advance();
      else begin
        mfs[0] = 0; mfs[1] = 0;
      end
    end
    #1 compare_all();
  endtask

  initial begin
    longint last_h0, last_f1;
    int n_fs1, n_wrap1;
    bit found;

    rst = 1'b1;
    en  = 1'b0;
    model_reset();
    #2;
    check("reset_hcount", int'(vif0.hcount), 0);
    check("reset_hsync_pol0", int'(vif1.hsync), 1);
    check("reset_vsync_pol0", int'(vif1.vsync), 1);
    check("reset_hsync_pol1", int'(vif0.hsync), 0);
    cycle(1'b1, 1'b1);
    cycle(1'b0, 1'b1);

    // First enabled edge after release must show pixel (1,0).
    cycle(1'b1, 1'b0);
    check("first_edge_h", int'(vif0.hcount), 1);
    check("first_edge_v", int'(vif0.vcount), 0);

    // Free run: line period on the default mode, frame period on the small mode.
    last_h0 = -1; last_f1 = -1; n_fs1 = 0; n_wrap1 = 0;
    for (int k = 0; k < 3300; k++) begin
      cycle(1'b1, 1'b0);
      if (vif0.hcount == 12'd0) begin
        if (last_h0 >= 0) check("line_period", int'(cyc - last_h0), 1056);
        last_h0 = cyc;
      end
      if (vif1.hcount == 12'd0 && vif1.vcount == 12'd0) n_wrap1++;
      if (fs1) begin
        n_fs1++;
        if (last_f1 >= 0) check("frame_period_small", int'(cyc - last_f1), 23 * 13);
        last_f1 = cyc;
      end
    end
    check("frame_start_count", n_fs1, n_wrap1);

    // Mid-line reset at hcount 500.
    found = 0;
    for (int k = 0; k < 2200 && !found; k++) begin
      if (mh[0] == 500) found = 1;
      else cycle(1'b1, 1'b0);
    end
    check("reach_h500", int'(found), 1);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    #1;
    check("midline_rst_h", int'(vif0.hcount), 0);
    check("midline_rst_v", int'(vif0.vcount), 0);
    check("midline_rst_hsync", int'(vif0.hsync), 0);
    check("midline_rst_hblnk", int'(vif0.hblnk), 0);
    compare_all();
    cycle(1'b1, 1'b1);

    // Enable gating at hcount 10.
    found = 0;
    for (int k = 0; k < 2200 && !found; k++) begin
      cycle(1'b1, 1'b0);
      if (mh[0] == 10) found = 1;
    end
    check("reach_h10", int'(found), 1);
    for (int k = 0; k < 7; k++) begin
      cycle(1'b0, 1'b0);
      check("gated_hold_h", int'(vif0.hcount), 10);
    end
    cycle(1'b1, 1'b0);
    check("gated_resume_h", int'(vif0.hcount), 11);

    // Randomized enable with rare resets.
    for (int k = 0; k < 20000; k++) begin
      cycle(($urandom_range(0, 9) != 0), ($urandom_range(0, 2999) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
